ram_scan_arbiter: RTL

//   Shares one single-port 32x3 RAM (1-cycle registered read) between a switch-driven user port (read/write)
//   and an auto-scan reader that steps through every address at a fixed rate and feeds the HEX display path.

---
 rtl/ram_scan_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ram_scan_arbiter.sv
// ram_scan_arbiter
//   Shares one single-port RAM (registered read, one-cycle latency) between a
//   user read/write port and a periodic auto-scan reader that walks every
//   address. One RAM access per cycle; contention is resolved round robin so a
//   continuously requesting side never waits more than one cycle.
//   A registered owner tag follows each access so the RAM output in the next
//   cycle is routed to the right consumer.
module ram_scan_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 3,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_gnt,
  output logic              usr_rvalid,
  output logic [DATA_W-1:0] usr_rdata,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic              scan_ovf,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  // A divide-by-1 still needs a one-bit counter so the compare stays legal.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_USR  = 2'd1,
    OWN_SCAN = 2'd2
  } owner_t;

  owner_t            owner_q;
  owner_t            owner_d;
  logic              last_scan;
  logic              usr_rd_tag;
  logic [ADDR_W-1:0] scan_addr_tag;
  logic [CNT_W-1:0]  div_cnt;
  logic [ADDR_W-1:0] scan_ptr;
  logic              scan_pend;
  logic              scan_gnt;
  logic              tick;

  assign tick = scan_en && (div_cnt == DIV_LAST);

  // Arbitration decision for this cycle and the RAM controls it implies.
  always_comb begin
    owner_d = OWN_IDLE;
    if (usr_req && scan_pend) begin
      owner_d = last_scan ? OWN_USR : OWN_SCAN;
    end else if (usr_req) begin
      owner_d = OWN_USR;
    end else if (scan_pend) begin
      owner_d = OWN_SCAN;
    end
  end

  assign usr_gnt   = (owner_d == OWN_USR);
  assign scan_gnt  = (owner_d == OWN_SCAN);
  assign ram_addr  = usr_gnt ? usr_addr : scan_ptr;
  assign ram_wdata = usr_wdata;
  assign ram_wren  = usr_gnt & usr_we;

  // Owner register plus the tags that say what the next ram_q belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q       <= OWN_IDLE;
      last_scan     <= 1'b1;
      usr_rd_tag    <= 1'b0;
      scan_addr_tag <= '0;
    end else begin
      owner_q    <= owner_d;
      usr_rd_tag <= usr_gnt & ~usr_we;
      if (usr_gnt) begin
        last_scan <= 1'b0;
      end else if (scan_gnt) begin
        last_scan     <= 1'b1;
        scan_addr_tag <= scan_ptr;
      end
    end
  end

  // Scan tick divider, pending flag, overflow flag and scan pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      scan_pend <= 1'b0;
      scan_ovf  <= 1'b0;
      scan_ptr  <= '0;
    end else begin
      if (!scan_en) begin
        div_cnt   <= '0;
        scan_pend <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
        if (tick) begin
          scan_pend <= 1'b1;
          if (scan_pend && !scan_gnt) begin
            scan_ovf <= 1'b1;
          end
        end else if (scan_gnt) begin
          scan_pend <= 1'b0;
        end
      end
      if (scan_gnt) begin
        scan_ptr <= scan_ptr + ADDR_W'(1);
      end
    end
  end

  // Route the RAM output to whichever side owned the previous cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      usr_rvalid <= 1'b0;
      usr_rdata  <= '0;
      scan_valid <= 1'b0;
      scan_addr  <= '0;
      scan_data  <= '0;
    end else begin
      usr_rvalid <= (owner_q == OWN_USR) && usr_rd_tag;
      scan_valid <= (owner_q == OWN_SCAN);
      if ((owner_q == OWN_USR) && usr_rd_tag) begin
        usr_rdata <= ram_q;
      end
      if (owner_q == OWN_SCAN) begin
        scan_addr <= scan_addr_tag;
        scan_data <= ram_q;
      end
    end
  end

endmodule
